// File: rtl/time_ctrl_pkg.sv
// Shared encodings and helpers for the time_counter user-interface controller.
// Holds FSM state/action types, time-field limits and small arithmetic helpers.
package time_ctrl_pkg;

   localparam int TIME_W = 8;
   localparam logic [TIME_W-1:0] MAX_HOURS   = 8'd23;
   localparam logic [TIME_W-1:0] MAX_MINUTES = 8'd59;

   typedef enum logic [1:0] {
      STOPPED     = 2'd0,
      RUNNING     = 2'd1,
      SET_HOURS   = 2'd2,
      SET_MINUTES = 2'd3
   } ctrl_state_t;

   // One action per cycle, already resolved by priority and by current state.
   typedef enum logic [2:0] {
      ACT_NONE  = 3'd0,
      ACT_START = 3'd1,
      ACT_MODE  = 3'd2,
      ACT_INC   = 3'd3,
      ACT_LONG  = 3'd4
   } ctrl_action_t;

   function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] max);
      logic [TIME_W-1:0] r;
      if (v >= max) r = {TIME_W{1'b0}};
      else          r = v + TIME_W'(1);
      return r;
   endfunction

   function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                    input logic [TIME_W-1:0] max);
      logic [TIME_W-1:0] r;
      if (v > max) r = {TIME_W{1'b0}};
      else         r = v;
      return r;
   endfunction

   function automatic ctrl_state_t next_state(input ctrl_state_t cur, input ctrl_action_t act);
      ctrl_state_t nxt;
      nxt = cur;
      case (act)
         ACT_START: nxt = (cur == STOPPED) ? RUNNING : STOPPED;
         ACT_LONG:  nxt = STOPPED;
         ACT_MODE: begin
            case (cur)
               STOPPED:   nxt = SET_HOURS;
               SET_HOURS: nxt = SET_MINUTES;
               default:   nxt = STOPPED;
            endcase
         end
         default:   nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button.
// Emits the debounced level and a one-cycle pulse on each accepted press.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Synchronize, then accept a new level only after it has differed long enough.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= {CNT_W{1'b0}};
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= {CNT_W{1'b0}};
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            press <= sync2;
            cnt   <= {CNT_W{1'b0}};
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/time_counter_ctrl.sv
// Button-driven controller for time_counter: run/stop, clear on long press,
// hour/minute editing with a load strobe, and display blink enables.
module time_counter_ctrl
   import time_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 5,
   parameter int LONG_PRESS_CYCLES = 500,
   parameter int BLINK_HALF_CYCLES = 125
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_start,
   input  logic              btn_mode,
   input  logic              btn_inc,
   input  logic [TIME_W-1:0] cur_hours,
   input  logic [TIME_W-1:0] cur_minutes,
   output logic              run,
   output logic              clear,
   output logic              load,
   output logic [TIME_W-1:0] load_hours,
   output logic [TIME_W-1:0] load_minutes,
   output logic              blink_hours,
   output logic              blink_minutes,
   output logic [1:0]        state
);

   localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
   localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LONG_PRESS_CYCLES - 1);
   localparam int BL_W = $clog2(BLINK_HALF_CYCLES);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);

   logic start_level, mode_level, inc_level, levels_unused;
   logic start_press, mode_press, inc_press;
   logic [LP_W-1:0] lp_cnt;
   logic            long_pulse;
   logic [BL_W-1:0] blink_cnt;
   logic            phase, phase_nx;
   ctrl_state_t     fsm_state, state_nx;
   ctrl_action_t    action;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk(clk), .reset(reset), .btn(btn_start), .level(start_level), .press(start_press));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .reset(reset), .btn(btn_mode), .level(mode_level), .press(mode_press));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk(clk), .reset(reset), .btn(btn_inc), .level(inc_level), .press(inc_press));

   assign levels_unused = mode_level ^ inc_level;
   assign state         = fsm_state;

   // Hold counter for start; fires once when the hold completes, re-arms on release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lp_cnt     <= {LP_W{1'b0}};
         long_pulse <= 1'b0;
      end else if (start_level) begin
         if (lp_cnt != LP_MAX) lp_cnt <= lp_cnt + LP_W'(1);
         long_pulse <= (lp_cnt == LP_FIRE);
      end else begin
         lp_cnt     <= {LP_W{1'b0}};
         long_pulse <= 1'b0;
      end
   end

   // Free-running blink phase generator.
   always_ff @(posedge clk) begin
      if (!reset) begin
         blink_cnt <= {BL_W{1'b0}};
         phase     <= 1'b0;
      end else if (blink_cnt == BL_LAST) begin
         blink_cnt <= {BL_W{1'b0}};
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BL_W'(1);
      end
   end

   assign phase_nx = (blink_cnt == BL_LAST) ? ~phase : phase;

   // Resolve simultaneous events: start beats everything; in STOPPED a long
   // press (clear) is taken ahead of a mode press.
   always_comb begin
      action = ACT_NONE;
      case (fsm_state)
         STOPPED: begin
            if (start_press)     action = ACT_START;
            else if (long_pulse) action = ACT_LONG;
            else if (mode_press) action = ACT_MODE;
            else                 action = ACT_NONE;
         end
         RUNNING: begin
            if (start_press)     action = ACT_START;
            else if (long_pulse) action = ACT_LONG;
            else                 action = ACT_NONE;
         end
         SET_HOURS, SET_MINUTES: begin
            if (start_press)     action = ACT_START;
            else if (mode_press) action = ACT_MODE;
            else if (inc_press)  action = ACT_INC;
            else                 action = ACT_NONE;
         end
         default: action = ACT_NONE;
      endcase
   end

   assign state_nx = next_state(fsm_state, action);

   // Control FSM with registered outputs and edit registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fsm_state     <= STOPPED;
         run           <= 1'b0;
         clear         <= 1'b0;
         load          <= 1'b0;
         load_hours    <= {TIME_W{1'b0}};
         load_minutes  <= {TIME_W{1'b0}};
         blink_hours   <= 1'b0;
         blink_minutes <= 1'b0;
      end else begin
         fsm_state     <= state_nx;
         run           <= (state_nx == RUNNING);
         clear         <= (action == ACT_LONG);
         load          <= (action == ACT_MODE) && (fsm_state == SET_MINUTES);
         blink_hours   <= phase_nx && (state_nx == SET_HOURS);
         blink_minutes <= phase_nx && (state_nx == SET_MINUTES);
         case (action)
            ACT_MODE: begin
               if (fsm_state == STOPPED) begin
                  load_hours   <= clamp_time(cur_hours, MAX_HOURS);
                  load_minutes <= clamp_time(cur_minutes, MAX_MINUTES);
               end
            end
            ACT_INC: begin
               if (fsm_state == SET_HOURS)
                  load_hours <= wrap_inc(load_hours, MAX_HOURS);
               else
                  load_minutes <= wrap_inc(load_minutes, MAX_MINUTES);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_time_counter_ctrl.sv
// Self-checking bench for time_counter_ctrl: directed scenarios plus random
// button traffic, compared every cycle against a behavioural model.
module tb_time_counter_ctrl;

   localparam int D  = 5;
   localparam int LP = 500;
   localparam int BH = 125;

   logic       clk, reset, btn_start, btn_mode, btn_inc;
   logic [7:0] cur_hours, cur_minutes;
   logic       run, clear, load, blink_hours, blink_minutes;
   logic [7:0] load_hours, load_minutes;
   logic [1:0] state;

   time_counter_ctrl #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(LP), .BLINK_HALF_CYCLES(BH)) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hours(cur_hours), .cur_minutes(cur_minutes), .run(run), .clear(clear), .load(load),
      .load_hours(load_hours), .load_minutes(load_minutes), .blink_hours(blink_hours),
      .blink_minutes(blink_minutes), .state(state));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state
   bit m_valid = 0;
   bit m_h1[3], m_h2[3], m_deb[3], m_press[3];
   int m_diff_run[3];
   int m_held, m_k, m_state, m_lh, m_lm;
   bit m_long, m_run, m_clear, m_load, m_bh, m_bm;

   // Running totals observed on DUT outputs
   int tot_run = 0, tot_clear = 0, tot_load = 0, tot_both = 0, tot_bh = 0, tot_bm = 0;
   int last_lh = -1, last_lm = -1;

   function automatic void model_step();
      bit raw_v[3];
      bit ps, pm, pi, lg, np;
      int ns, nlh, nlm;
      raw_v[0] = btn_start; raw_v[1] = btn_mode; raw_v[2] = btn_inc;
      if (!reset) begin
         m_valid = 1;
         for (int b = 0; b < 3; b++) begin
            m_h1[b] = 0; m_h2[b] = 0; m_deb[b] = 0; m_press[b] = 0; m_diff_run[b] = 0;
         end
         m_held = 0; m_long = 0; m_k = 0; m_state = 0; m_lh = 0; m_lm = 0;
         m_run = 0; m_clear = 0; m_load = 0; m_bh = 0; m_bm = 0;
         return;
      end
      ps = m_press[0]; pm = m_press[1]; pi = m_press[2]; lg = m_long;
      ns = m_state; nlh = m_lh; nlm = m_lm; m_clear = 0; m_load = 0;
      if (ps) ns = (m_state == 0) ? 1 : 0;
      else begin
         case (m_state)
            0: if (lg) m_clear = 1;
               else if (pm) begin
                  ns = 2;
                  nlh = (cur_hours > 23) ? 0 : int'(cur_hours);
                  nlm = (cur_minutes > 59) ? 0 : int'(cur_minutes);
               end
            1: if (lg) begin ns = 0; m_clear = 1; end
            2: if (pm) ns = 3; else if (pi) nlh = (m_lh + 1) % 24;
            3: if (pm) begin ns = 0; m_load = 1; end else if (pi) nlm = (m_lm + 1) % 60;
            default: ;
         endcase
      end
      // long pulse: debounced start has been high for exactly LP sampled edges
      if (m_deb[0]) m_held++; else m_held = 0;
      m_long = m_deb[0] && (m_held == LP);
      // debounce: synced value must differ from accepted value on D+1 edges in a row
      for (int b = 0; b < 3; b++) begin
         np = 0;
         if (m_h2[b] != m_deb[b]) begin
            m_diff_run[b]++;
            if (m_diff_run[b] == D + 1) begin
               m_deb[b] = m_h2[b];
               np = m_h2[b];
               m_diff_run[b] = 0;
            end
         end else m_diff_run[b] = 0;
         m_press[b] = np;
         m_h2[b] = m_h1[b];
         m_h1[b] = raw_v[b];
      end
      m_k++;
      m_state = ns; m_lh = nlh; m_lm = nlm;
      m_run = (ns == 1);
      m_bh = (((m_k / BH) % 2) == 1) && (ns == 2);
      m_bm = (((m_k / BH) % 2) == 1) && (ns == 3);
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      cmp(name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) begin
         vectors++;
         cmp("run", run, m_run);
         cmp("clear", clear, m_clear);
         cmp("load", load, m_load);
         cmp("load_hours", load_hours, m_lh);
         cmp("load_minutes", load_minutes, m_lm);
         cmp("blink_hours", blink_hours, m_bh);
         cmp("blink_minutes", blink_minutes, m_bm);
         cmp("state", state, m_state);
      end
      tot_run += run; tot_clear += clear; tot_load += load;
      tot_bh += blink_hours; tot_bm += blink_minutes;
      if (clear && load) tot_both++;
      if (load) begin last_lh = load_hours; last_lm = load_minutes; end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_start = v;
         1: btn_mode = v;
         default: btn_inc = v;
      endcase
   endtask

   task automatic press(input int b, input int hold);
      set_btn(b, 1'b1);
      repeat (hold) tick();
      set_btn(b, 1'b0);
      repeat (12) tick();
   endtask

   task automatic check_all_zero(input string tag);
      lit({tag, "_run"}, run, 0);
      lit({tag, "_clear"}, clear, 0);
      lit({tag, "_load"}, load, 0);
      lit({tag, "_state"}, state, 0);
      lit({tag, "_lh"}, load_hours, 0);
      lit({tag, "_lm"}, load_minutes, 0);
      lit({tag, "_bh"}, blink_hours, 0);
      lit({tag, "_bm"}, blink_minutes, 0);
   endtask

   int snap, snap2;
   int remain[3];
   bit lvl[3];

   initial begin
      reset = 1'b0; btn_start = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      cur_hours = 8'd0; cur_minutes = 8'd0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b1;
      repeat (5) tick();

      // Start toggle with exact latency
      btn_start = 1'b1;
      repeat (D + 3) tick();
      lit("run_before_latency", run, 0);
      tick();
      lit("run_at_latency", run, 1);
      lit("state_running", state, 1);
      repeat (20 - (D + 4)) tick();
      btn_start = 1'b0;
      repeat (12) tick();
      press(0, 20);
      lit("run_after_stop", run, 0);
      lit("state_after_stop", state, 0);

      // Bounce rejection
      snap = tot_run;
      for (int i = 0; i < 10; i++) begin
         btn_start = 1'b1;
         repeat (1 + (i % 4)) tick();
         btn_start = 1'b0;
         repeat (8) tick();
      end
      lit("bounce_run_cycles", tot_run - snap, 0);

      // Edit with wrap
      cur_hours = 8'd22; cur_minutes = 8'd58;
      snap = tot_load;
      press(1, 8);
      lit("edit_state_sethours", state, 2);
      lit("edit_capture_h", load_hours, 22);
      lit("edit_capture_m", load_minutes, 58);
      press(2, 8); press(2, 8);
      lit("edit_hours_wrapped", load_hours, 0);
      press(1, 8);
      lit("edit_state_setmin", state, 3);
      press(2, 8); press(2, 8); press(2, 8);
      press(1, 8);
      lit("edit_load_cycles", tot_load - snap, 1);
      lit("edit_load_h", last_lh, 0);
      lit("edit_load_m", last_lm, 1);
      lit("edit_state_done", state, 0);

      // Abort from SET_MINUTES
      snap = tot_load;
      press(1, 8); press(1, 8);
      lit("abort_in_setmin", state, 3);
      press(0, 8);
      lit("abort_state", state, 0);
      lit("abort_no_load", tot_load - snap, 0);

      // Long press while running
      press(0, 8);
      lit("long_running", run, 1);
      snap = tot_clear;
      btn_start = 1'b1;
      repeat (600) tick();
      lit("long_one_clear_held", tot_clear - snap, 1);
      btn_start = 1'b0;
      repeat (15) tick();
      lit("long_one_clear_total", tot_clear - snap, 1);
      lit("long_run_off", run, 0);
      lit("long_state", state, 0);

      // Reset mid-edit, blink duty in SET_HOURS
      cur_hours = 8'd0; cur_minutes = 8'd10;
      press(1, 8);
      for (int i = 0; i < 5; i++) press(2, 8);
      lit("midedit_lh5", load_hours, 5);
      snap = tot_bh; snap2 = tot_bm;
      repeat (260) tick();
      lit("blink_h_duty_ok", ((tot_bh - snap) >= 125 && (tot_bh - snap) <= 135) ? 1 : 0, 1);
      lit("blink_m_off", tot_bm - snap2, 0);
      reset = 1'b0;
      tick();
      check_all_zero("midreset");
      reset = 1'b1;
      cur_hours = 8'd7; cur_minutes = 8'd30;
      repeat (4) tick();
      press(1, 8);
      lit("fresh_capture_h", load_hours, 7);
      lit("fresh_capture_m", load_minutes, 30);
      press(0, 8);

      // Out-of-range capture clamps to zero
      cur_hours = 8'd40; cur_minutes = 8'd70;
      press(1, 8);
      lit("clamp_h", load_hours, 0);
      lit("clamp_m", load_minutes, 0);
      press(0, 8);

      // Random traffic
      for (int b = 0; b < 3; b++) begin remain[b] = 0; lvl[b] = 0; end
      for (int c = 0; c < 6000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (remain[b] == 0) begin
               lvl[b] = ~lvl[b];
               if ($urandom_range(0, 9) < 3) remain[b] = $urandom_range(1, 5);
               else remain[b] = $urandom_range(6, 40);
               if (b == 0 && lvl[b] && $urandom_range(0, 39) == 0) remain[b] = $urandom_range(500, 560);
            end
            remain[b]--;
            set_btn(b, lvl[b]);
         end
         if ($urandom_range(0, 49) == 0) begin
            cur_hours = 8'($urandom_range(0, 30));
            cur_minutes = 8'($urandom_range(0, 70));
         end
         reset = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      reset = 1'b1;
      lit("never_clear_and_load", tot_both, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/time_counter_ctrl.md
Name: time_counter_ctrl

Overview:
- User-interface controller that sequences `time_counter`.
- Debounces three raw push-buttons and drives `time_counter`'s `startStop` (run) input. Issues clear pulses and a load strobe with operator-set hours/minutes.
- Generates blink enables for the display.
- Sits between the board buttons and `time_counter`, in the 250 Hz `clk_gen` domain.

Parameters:
- DEBOUNCE_CYCLES, 5: consecutive stable samples before a button change is accepted (20 ms at 250 Hz).
- LONG_PRESS_CYCLES, 500: cycles `btn_start` must stay debounced-high to issue a clear (2 s).
- BLINK_HALF_CYCLES, 125: blink phase half-period (0.5 s).

Ports:
- clk  in  1  system clock, 250 Hz
- reset  in  1  synchronous, active-low reset
- btn_start  in  1  raw start/stop button, asynchronous
- btn_mode  in  1  raw mode/set button, asynchronous
- btn_inc  in  1  raw increment button, asynchronous
- cur_hours  in  8  current hours from time_counter, binary 0..23
- cur_minutes  in  8  current minutes from time_counter, binary 0..59
- run  out  1  level; drives time_counter startStop
- clear  out  1  one-cycle pulse; zeroes time_counter
- load  out  1  one-cycle pulse; time_counter loads load_hours/load_minutes, seconds=0
- load_hours  out  8  edit register, hours
- load_minutes  out  8  edit register, minutes
- blink_hours  out  1  display blank enable for hours digits
- blink_minutes  out  1  display blank enable for minutes digits
- state  out  2  current FSM state, for debug

Behaviour:
- Reset (reset==0 at a clk edge) has the following effect:
  - All outputs go to 0 and state goes to STOPPED.
  - Debouncers clear; synchronizers and debounced values go to 0. Long-press counter and blink counter go to 0.
  - Reset wins over every other event, including mid-edit (edit values are discarded, no load issued).
- Debounce, per button:
  - Input passes a 2-FF synchronizer.
  - A counter increments while the synced value differs from the debounced value, and zeroes when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synced value.
  - A debounced 0->1 transition yields a one-cycle press pulse.
  - A clean raw rise sampled first at edge N gives a press pulse high during cycle N+DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Long press:
  - Counter runs while debounced `btn_start` is 1, and saturates.
  - On reaching LONG_PRESS_CYCLES it emits one long pulse; no repeat until release.
- FSM states, encoded 2-bit:
  - STOPPED=0
  - RUNNING=1
  - SET_HOURS=2
  - SET_MINUTES=3
- FSM transitions:
  - STOPPED:
    - start press -> RUNNING.
    - mode press -> SET_HOURS; edit registers capture cur_hours/cur_minutes.
    - long pulse -> clear=1 for one cycle, stay STOPPED.
  - RUNNING:
    - start press -> STOPPED.
    - long pulse -> clear, state becomes STOPPED.
    - mode and inc presses ignored.
  - SET_HOURS:
    - inc press: load_hours = 23 ? 0 : +1.
    - mode press -> SET_MINUTES.
    - start press -> STOPPED, no load.
  - SET_MINUTES:
    - inc press: load_minutes = 59 ? 0 : +1.
    - mode press -> load=1 for one cycle, -> STOPPED.
    - start press -> STOPPED, no load.
  - Long pulse is ignored in both SET states.
- Simultaneous press pulses in one cycle: priority is start > mode > inc. Only the highest is acted on; the others are dropped.
- All outputs are registered and change at the edge following the cycle the press/long pulse is high.
  - run = 1 exactly in RUNNING.
  - clear and load are never high together.
- Blink:
  - A free-running counter toggles the phase every BLINK_HALF_CYCLES.
  - blink_hours = phase & (state==SET_HOURS).
  - blink_minutes = phase & (state==SET_MINUTES).
- Arithmetic: edit registers are unsigned 8-bit binary and never exceed 23/59.
- Captured cur_* values outside range (hours >23 or minutes >59) are clamped to 0.

Decomposition:
- Package `time_ctrl_pkg` holds:
  - state encodings STOPPED/RUNNING/SET_HOURS/SET_MINUTES
  - MAX_HOURS=23
  - MAX_MINUTES=59
  - TIME_W=8
- One sub-module, `button_debouncer` (sync + debounce + press pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- FSM, long-press, edit registers and blink logic live in the top.

Test Plan:
- Start toggle: btn_start high 20 cycles from STOPPED -> run=1 at cycle DEBOUNCE_CYCLES+3 after the rise. A second press -> run=0, state=0.
- Bounce rejection: btn_start pulses of 1-4 cycles, repeated 10x -> no press pulse, run stays 0.
- Edit with wrap: cur_hours=22, cur_minutes=58. Sequence mode, inc x2, mode, inc x3, mode:
  - load=1 for exactly one cycle with load_hours=0, load_minutes=1.
  - state returns to 0.
- Abort: in SET_MINUTES press btn_start -> state=STOPPED, load never asserted.
- Long press: running, hold btn_start 600 cycles -> run=0 after the press, then one clear pulse when the 500-cycle hold completes, no second clear before release.
- Reset mid-edit: reset=0 for 1 cycle in SET_HOURS with load_hours=5 -> all outputs 0, state=0; next mode press captures cur_* fresh.
